// File: rtl/pattern_gen_pkg.sv
// Shared definitions for the test-pattern generator: pattern mode encodings
// and the default visible raster size.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_SPLIT = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int V_ACTIVE_DEFAULT = 480;

endpackage

// File: rtl/pattern_gen_box_mover.sv
// One axis of the bouncing box: position and travel direction, stepped once
// per frame and clamped so the box never touches the screen border.
module box_mover #(
  parameter int LIMIT    = 640,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic       clk_d,
  input  logic       reset,
  input  logic       step_en,
  output logic [9:0] pos,
  output logic       dir
);

  // Comparisons are done one bit wider so pos+STEP cannot wrap.
  localparam logic [10:0] MAX_POS = 11'(LIMIT - 1 - BOX_SIZE);
  localparam logic [10:0] MIN_FWD = 11'(1 + STEP);

  logic [10:0] pos_ext;
  logic [10:0] pos_up;

  assign pos_ext = {1'b0, pos};
  assign pos_up  = pos_ext + 11'(STEP);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      pos <= 10'd1;
      dir <= 1'b1;
    end else if (step_en) begin
      if (dir) begin
        if (pos_up > MAX_POS) begin
          pos <= MAX_POS[9:0];
          dir <= 1'b0;
        end else begin
          pos <= pos_up[9:0];
        end
      end else begin
        if (pos_ext < MIN_FWD) begin
          pos <= 10'd1;
          dir <= 1'b1;
        end else begin
          pos <= pos - 10'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/pattern_gen.sv
// Test-pattern generator: turns sync-generator coordinates into registered
// RGB for four selectable patterns, plus an end-of-frame tick.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int CW       = 4,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic          clk_d,
  input  logic          reset,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          video_on,
  input  logic [1:0]    mode,
  output logic [CW-1:0] red,
  output logic [CW-1:0] green,
  output logic [CW-1:0] blue,
  output logic          frame_tick
);

  localparam logic [CW-1:0] ONES     = '1;
  localparam logic [CW-1:0] MSB_ONLY = CW'(1) << (CW - 1);
  localparam logic [9:0]    X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]    Y_HALF   = 10'(V_ACTIVE / 2);
  localparam logic [9:0]    BAR_W    = 10'(H_ACTIVE / 8);
  localparam logic [10:0]   BOX_SPAN = 11'(BOX_SIZE - 1);

  mode_e       active_mode;
  logic [9:0]  box_x;
  logic [9:0]  box_y;
  logic        dir_x;
  logic        dir_y;
  logic        frame_start;
  logic        frame_end;
  logic        on_border;
  logic        in_box;
  logic [2:0]  bar;
  logic [CW-1:0] red_nxt;
  logic [CW-1:0] green_nxt;
  logic [CW-1:0] blue_nxt;

  assign frame_start = video_on && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign frame_end   = video_on && (pixel_x == X_LAST) && (pixel_y == Y_LAST);
  assign on_border   = (pixel_x == 10'd0) || (pixel_x == X_LAST) ||
                       (pixel_y == 10'd0) || (pixel_y == Y_LAST);
  assign bar         = 3'(pixel_x / BAR_W);
  assign in_box      = ({1'b0, pixel_x} >= {1'b0, box_x}) &&
                       ({1'b0, pixel_x} <= {1'b0, box_x} + BOX_SPAN) &&
                       ({1'b0, pixel_y} >= {1'b0, box_y}) &&
                       ({1'b0, pixel_y} <= {1'b0, box_y} + BOX_SPAN);

  box_mover #(.LIMIT(H_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP)) u_box_x (
    .clk_d   (clk_d),
    .reset   (reset),
    .step_en (frame_end),
    .pos     (box_x),
    .dir     (dir_x)
  );

  box_mover #(.LIMIT(V_ACTIVE), .BOX_SIZE(BOX_SIZE), .STEP(STEP)) u_box_y (
    .clk_d   (clk_d),
    .reset   (reset),
    .step_en (frame_end),
    .pos     (box_y),
    .dir     (dir_y)
  );

  // Mode is latched only on the first visible pixel; the frame-start pixel
  // itself is a border pixel, so it never shows the new pattern.
  always_ff @(posedge clk_d) begin
    if (reset) begin
      active_mode <= MODE_SPLIT;
    end else if (frame_start) begin
      active_mode <= mode_e'(mode);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    red_nxt   = '0;
    green_nxt = '0;
    blue_nxt  = '0;
    if (video_on) begin
      if (on_border) begin
        red_nxt   = ONES;
        green_nxt = ONES;
        blue_nxt  = ONES;
      end else begin
        unique case (active_mode)
          MODE_SPLIT: red_nxt = (pixel_y >= Y_HALF) ? ONES : '0;
          MODE_BARS: begin
            red_nxt   = bar[2] ? ONES : '0;
            green_nxt = bar[1] ? ONES : '0;
            blue_nxt  = bar[0] ? ONES : '0;
          end
          MODE_CHECK: begin
            red_nxt   = (pixel_x[5] ^ pixel_y[5]) ? ONES : '0;
            green_nxt = red_nxt;
            blue_nxt  = red_nxt;
          end
          MODE_BOX: begin
            if (in_box) green_nxt = ONES;
            else        blue_nxt  = MSB_ONLY;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_d) begin
    if (reset) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      frame_tick <= 1'b0;
    end else begin
      red        <= red_nxt;
      green      <= green_nxt;
      blue       <= blue_nxt;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: drives coordinates directly, so a "frame"
// is just a frame-start pixel, a few probe pixels and a frame-end pixel.
module tb_pattern_gen;

  logic       clk_d = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic       video_on = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int n_ticks  = 0;

  pattern_gen dut (
    .clk_d      (clk_d),
    .reset      (reset),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .video_on   (video_on),
    .mode       (mode),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_tick (frame_tick)
  );

  always #5 clk_d = ~clk_d;

  // Present one pixel and return 1 time unit after the edge that registers it.
  task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic von);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    @(posedge clk_d);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix(10'd0, 10'd0, 1'b0);
    reset = 1'b0;
  endtask

  // Frame start, frame end, one blank cycle; checks the tick pulse width.
  task automatic run_frame();
    pix(10'd0, 10'd0, 1'b1);
    pix(10'd639, 10'd479, 1'b1);
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_errors++;
      $display("FAIL frame_tick_high: got %b want 1", frame_tick);
    end else begin
      n_ticks++;
    end
    pix(10'd0, 10'd0, 1'b0);
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_errors++;
      $display("FAIL frame_tick_width: got %b want 0", frame_tick);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix(10'd5, 10'd5, 1'b1);
    n_checks++;
    if ({red, green, blue, frame_tick} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rgb=%h tick=%b want rgb=000 tick=0", {red, green, blue}, frame_tick);
    end
    reset = 1'b0;
  endtask

  task automatic test_bars();
    do_reset();
    mode = 2'd1;
    pix(10'd0, 10'd0, 1'b1);
    pix(10'd100, 10'd50, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h00F) begin
      n_errors++;
      $display("FAIL bars_100_50: got %h want 00f", {red, green, blue});
    end
    pix(10'd600, 10'd50, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      n_errors++;
      $display("FAIL bars_600_50: got %h want fff", {red, green, blue});
    end
    pix(10'd200, 10'd50, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL bars_200_50: got %h want 0f0", {red, green, blue});
    end
    pix(10'd400, 10'd50, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hF0F) begin
      n_errors++;
      $display("FAIL bars_400_50: got %h want f0f", {red, green, blue});
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 2'd0;
    pix(10'd0, 10'd0, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      n_errors++;
      $display("FAIL switch_start_border: got %h want fff", {red, green, blue});
    end
    mode = 2'd2;
    pix(10'd300, 10'd200, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h000) begin
      n_errors++;
      $display("FAIL switch_300_200: got %h want 000", {red, green, blue});
    end
    pix(10'd300, 10'd300, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hF00) begin
      n_errors++;
      $display("FAIL switch_still_split: got %h want f00", {red, green, blue});
    end
    pix(10'd639, 10'd479, 1'b1);
    pix(10'd0, 10'd0, 1'b1);
    pix(10'd33, 10'd1, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      n_errors++;
      $display("FAIL checker_33_1: got %h want fff", {red, green, blue});
    end
    pix(10'd0, 10'd200, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      n_errors++;
      $display("FAIL border_0_200: got %h want fff", {red, green, blue});
    end
    pix(10'd33, 10'd33, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h000) begin
      n_errors++;
      $display("FAIL checker_33_33: got %h want 000", {red, green, blue});
    end
  endtask

  task automatic test_blanking();
    do_reset();
    mode = 2'd0;
    pix(10'd0, 10'd0, 1'b1);
    pix(10'd320, 10'd300, 1'b0);
    n_checks++;
    if ({red, green, blue} !== 12'h000) begin
      n_errors++;
      $display("FAIL blank_320_300: got %h want 000", {red, green, blue});
    end
    pix(10'd320, 10'd300, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hF00) begin
      n_errors++;
      $display("FAIL split_320_300: got %h want f00", {red, green, blue});
    end
    pix(10'd320, 10'd239, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h000) begin
      n_errors++;
      $display("FAIL split_320_239: got %h want 000", {red, green, blue});
    end
    pix(10'd320, 10'd240, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hF00) begin
      n_errors++;
      $display("FAIL split_320_240: got %h want f00", {red, green, blue});
    end
    pix(10'd0, 10'd0, 1'b0);
    n_checks++;
    if ({red, green, blue} !== 12'h000) begin
      n_errors++;
      $display("FAIL blank_origin: got %h want 000", {red, green, blue});
    end
  endtask

  task automatic test_borders();
    pix(10'd639, 10'd100, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      n_errors++;
      $display("FAIL border_right: got %h want fff", {red, green, blue});
    end
    pix(10'd100, 10'd479, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hFFF) begin
      n_errors++;
      $display("FAIL border_bottom: got %h want fff", {red, green, blue});
    end
    pix(10'd639, 10'd478, 1'b1);
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_errors++;
      $display("FAIL tick_not_end: got %b want 0", frame_tick);
    end
    pix(10'd639, 10'd479, 1'b0);
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_errors++;
      $display("FAIL tick_blanked: got %b want 0", frame_tick);
    end
  endtask

  task automatic test_box();
    int ticks_before;
    do_reset();
    mode = 2'd3;
    ticks_before = n_ticks;
    for (int f = 0; f < 3; f++) run_frame();
    n_checks++;
    if (n_ticks - ticks_before != 3) begin
      n_errors++;
      $display("FAIL tick_count: got %0d want 3", n_ticks - ticks_before);
    end
    pix(10'd7, 10'd7, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL box_7_7: got %h want 0f0", {red, green, blue});
    end
    pix(10'd6, 10'd7, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL box_6_7: got %h want 008", {red, green, blue});
    end
    pix(10'd38, 10'd38, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL box_38_38: got %h want 0f0", {red, green, blue});
    end
    pix(10'd39, 10'd7, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL box_39_7: got %h want 008", {red, green, blue});
    end
  endtask

  // Continues from test_box (3 frames done): x climbs 2/frame to 607, y has
  // already bounced off 447 at frame 224 and is descending.
  task automatic test_box_bounce();
    for (int f = 3; f < 303; f++) run_frame();
    pix(10'd607, 10'd289, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL bounce_f303_in: got %h want 0f0", {red, green, blue});
    end
    pix(10'd606, 10'd289, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL bounce_f303_left: got %h want 008", {red, green, blue});
    end
    run_frame();
    pix(10'd638, 10'd287, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL clamp_f304_edge: got %h want 0f0", {red, green, blue});
    end
    pix(10'd606, 10'd287, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL clamp_f304_left: got %h want 008", {red, green, blue});
    end
    run_frame();
    pix(10'd605, 10'd285, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL back_f305_in: got %h want 0f0", {red, green, blue});
    end
    pix(10'd604, 10'd285, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL back_f305_left: got %h want 008", {red, green, blue});
    end
    pix(10'd637, 10'd285, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL back_f305_right: got %h want 008", {red, green, blue});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    mode = 2'd2;
    run_frame();
    run_frame();
    pix(10'd0, 10'd0, 1'b1);
    pix(10'd100, 10'd100, 1'b1);
    reset = 1'b1;
    pix(10'd320, 10'd240, 1'b1);
    n_checks++;
    if ({red, green, blue, frame_tick} !== 13'h0) begin
      n_errors++;
      $display("FAIL midreset_out: got rgb=%h tick=%b want rgb=000 tick=0", {red, green, blue}, frame_tick);
    end
    reset = 1'b0;
    pix(10'd400, 10'd300, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'hF00) begin
      n_errors++;
      $display("FAIL midreset_mode0: got %h want f00", {red, green, blue});
    end
    mode = 2'd3;
    pix(10'd0, 10'd0, 1'b1);
    pix(10'd2, 10'd2, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h0F0) begin
      n_errors++;
      $display("FAIL midreset_box_in: got %h want 0f0", {red, green, blue});
    end
    pix(10'd33, 10'd2, 1'b1);
    n_checks++;
    if ({red, green, blue} !== 12'h008) begin
      n_errors++;
      $display("FAIL midreset_box_out: got %h want 008", {red, green, blue});
    end
  endtask

  initial begin
    test_reset();
    test_bars();
    test_mode_switch();
    test_blanking();
    test_borders();
    test_box();
    test_box_bounce();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
